// File: rtl/rnd_pkg.sv
// Shared definitions for the Galois LFSR generator and its checker.
// Holds default tap masks, checker state encoding and the step function.
package rnd_pkg;

   localparam logic [7:0]  TAPS8  = 8'hB8;
   localparam logic [15:0] TAPS16 = 16'hB400;
   localparam logic [31:0] TAPS32 = 32'h8020_0003;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      PRIMED = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   // Width-agnostic step; callers zero-extend and take their low bits.
   function automatic logic [31:0] lfsr_nxt(input logic [31:0] s,
                                            input logic [31:0] taps);
      return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
   endfunction

endpackage

// File: rtl/rnd_chk.sv
// Self-synchronising checker for the rnd_gen Galois LFSR stream.
// Locks after a run of correct predictions and flywheels through errors.
module rnd_chk
   import rnd_pkg::*;
#(
   parameter int          WIDTH    = 8,
   parameter logic [31:0] TAPS     = 32'h0000_00B8,
   parameter int          LOCK_CNT = 4,
   parameter int          LOSS_CNT = 3,
   parameter int          ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic             lost_sticky,
   output logic             zero_sticky
);

   localparam logic [31:0] TMASK = 32'(TAPS[WIDTH-1:0]);

   chk_state_t       state_q, state_d;
   logic [WIDTH-1:0] pred_q, pred_d;
   logic [3:0]       hit_q, hit_d;
   logic [3:0]       miss_q, miss_d;
   logic             pulse_q, pulse_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;
   logic             lost_q, lost_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] step_in, step_pred;
   logic             is_zero, hit;

   assign step_in   = WIDTH'(lfsr_nxt(32'(in_data), TMASK));
   assign step_pred = WIDTH'(lfsr_nxt(32'(pred_q), TMASK));
   assign is_zero   = (in_data == '0);
   assign hit       = (in_data == pred_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEARCH;
         pred_q  <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
         lost_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pred_q  <= pred_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
         lost_q  <= lost_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pred_d  = pred_q;
      hit_d   = hit_q;
      miss_d  = miss_q;
      pulse_d = 1'b0;
      cnt_d   = cnt_q;
      lost_d  = lost_q;
      zero_d  = zero_q;
      if (in_valid) begin
         if (is_zero) zero_d = 1'b1;
         unique case (state_q)
            SEARCH: begin
               if (!is_zero) begin
                  pred_d  = step_in;
                  hit_d   = '0;
                  state_d = PRIMED;
               end
            end
            PRIMED: begin
               if (hit) begin
                  hit_d  = hit_q + 4'd1;
                  pred_d = step_in;
                  if (hit_q == 4'(LOCK_CNT - 1)) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end
               end else if (!is_zero) begin
                  pred_d = step_in;
                  hit_d  = '0;
               end else begin
                  state_d = SEARCH;
               end
            end
            LOCKED: begin
               if (hit) begin
                  pred_d = step_in;
                  miss_d = '0;
               end else begin
                  // Flywheel: keep the local sequence, ignore the bad sample.
                  pulse_d = 1'b1;
                  pred_d  = step_pred;
                  miss_d  = miss_q + 4'd1;
                  if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
                  if (miss_q == 4'(LOSS_CNT - 1)) begin
                     state_d = SEARCH;
                     lost_d  = 1'b1;
                  end
               end
            end
            default: state_d = SEARCH;
         endcase
      end
      if (clr) begin
         cnt_d  = '0;
         lost_d = 1'b0;
         zero_d = 1'b0;
      end
   end

   assign locked      = (state_q == LOCKED);
   assign err_pulse   = pulse_q;
   assign err_count   = cnt_q;
   assign lost_sticky = lost_q;
   assign zero_sticky = zero_q;

endmodule

// File: tb/tb_rnd_chk.sv
// Randomised and directed bench for rnd_chk against a behavioural model.
// A narrow error counter keeps the saturation scenario short.
module tb_rnd_chk;

   localparam int EW   = 12;
   localparam int LOCK = 4;
   localparam int LOSS = 3;
   localparam int TAPV = 'hB8;
   localparam int EMAX = (1 << EW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = '0;
   logic          locked, err_pulse, lost_sticky, zero_sticky;
   logic [EW-1:0] err_count;

   int checks = 0;
   int failures = 0;

   // model: mode 0 = hunting, 1 = collecting hits, 2 = locked
   int m_mode, m_pred, m_hit, m_miss, m_cnt;
   bit m_pulse, m_lost, m_zero;
   int g;

   rnd_chk #(
      .WIDTH(8), .TAPS(32'hB8), .LOCK_CNT(LOCK),
      .LOSS_CNT(LOSS), .ERR_W(EW)
   ) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_data(in_data),
      .locked(locked), .err_pulse(err_pulse),
      .err_count(err_count),
      .lost_sticky(lost_sticky), .zero_sticky(zero_sticky)
   );

   always #5 clk = ~clk;

   function automatic int nx(input int s);
      return (s % 2 == 1) ? ((s / 2) ^ TAPV) : (s / 2);
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_pred = 0; m_hit = 0; m_miss = 0; m_cnt = 0;
      m_pulse = 0; m_lost = 0; m_zero = 0;
   endfunction

   function automatic void model(input bit v, input int d, input bit c);
      m_pulse = 0;
      if (v) begin
         if (d == 0) m_zero = 1;
         if (m_mode == 0) begin
            if (d != 0) begin m_pred = nx(d); m_hit = 0; m_mode = 1; end
         end else if (m_mode == 1) begin
            if (d == m_pred) begin
               m_hit++;
               m_pred = nx(d);
               if (m_hit == LOCK) begin m_mode = 2; m_miss = 0; end
            end else if (d != 0) begin
               m_pred = nx(d); m_hit = 0;
            end else m_mode = 0;
         end else begin
            if (d == m_pred) begin
               m_pred = nx(d); m_miss = 0;
            end else begin
               m_pulse = 1;
               if (m_cnt < EMAX) m_cnt++;
               m_pred = nx(m_pred);
               m_miss++;
               if (m_miss == LOSS) begin m_mode = 0; m_lost = 1; end
            end
         end
      end
      if (c) begin m_cnt = 0; m_lost = 0; m_zero = 0; end
   endfunction

   task automatic step(input bit v, input int d, input bit c);
      in_valid = v; in_data = 8'(d); clr = c;
      @(posedge clk);
      model(v, d, c);
      #1;
      in_valid = 1'b0; clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
      #1;
   endtask

   // seed plus LOCK matching samples; leaves g at the next expected value
   task automatic lock_from(input int seed);
      g = seed;
      for (int i = 0; i <= LOCK; i++) begin
         step(1, g, 0);
         g = nx(g);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({locked, err_pulse, lost_sticky, zero_sticky} !== 4'b0 ||
          err_count !== '0) begin
         failures++;
         $display("FAIL reset: flags=%b cnt=%0h want 0", {locked, err_pulse,
                  lost_sticky, zero_sticky}, err_count);
      end
   endtask

   task automatic test_lock();
      bit pulsed = 0;
      do_reset();
      g = 1;
      for (int i = 0; i < 5; i++) begin
         step(1, g, 0);
         g = nx(g);
         if (err_pulse) pulsed = 1;
         if (i == 3) begin
            checks++;
            if (locked !== 1'b0) begin
               failures++;
               $display("FAIL lock_early: locked=%b want 0", locked);
            end
         end
      end
      checks++;
      if (locked !== 1'b1 || err_count !== '0 || pulsed) begin
         failures++;
         $display("FAIL lock: locked=%b cnt=%0h pulse=%b want 1 0 0",
                  locked, err_count, pulsed);
      end
      checks++;
      if (g !== 'hB3) begin
         failures++;
         $display("FAIL lock_seq: next=%0h want b3", g);
      end
   endtask

   task automatic test_single_corrupt();
      int pulses = 0;
      step(1, g, 0); g = nx(g);
      if (err_pulse) pulses++;
      step(1, 'hFF, 0); g = nx(g);
      checks++;
      if (err_pulse !== 1'b1) begin
         failures++;
         $display("FAIL corrupt_pulse: pulse=%b want 1", err_pulse);
      end
      for (int i = 0; i < 6; i++) begin
         step(1, g, 0); g = nx(g);
         if (err_pulse) pulses++;
      end
      checks++;
      if (pulses != 0 || err_count !== EW'(1) || locked !== 1'b1) begin
         failures++;
         $display("FAIL corrupt: extra=%0d cnt=%0h locked=%b want 0 1 1",
                  pulses, err_count, locked);
      end
   endtask

   task automatic test_loss();
      do_reset();
      lock_from(1);
      for (int i = 0; i < 3; i++) begin
         step(1, 'hAA, 0);
         if (i < 2) begin
            checks++;
            if (locked !== 1'b1) begin
               failures++;
               $display("FAIL loss_early%0d: locked=%b want 1", i, locked);
            end
         end
      end
      checks++;
      if (err_count !== EW'(3) || locked !== 1'b0 || lost_sticky !== 1'b1
          || err_pulse !== 1'b1) begin
         failures++;
         $display("FAIL loss: cnt=%0h lk=%b lost=%b p=%b want 3 0 1 1",
                  err_count, locked, lost_sticky, err_pulse);
      end
      lock_from('h5A);
      checks++;
      if (locked !== 1'b1 || err_count !== EW'(3)) begin
         failures++;
         $display("FAIL relock: locked=%b cnt=%0h want 1 3",
                  locked, err_count);
      end
   endtask

   task automatic test_zero_gaps();
      do_reset();
      step(1, 0, 0);
      checks++;
      if (zero_sticky !== 1'b1 || locked !== 1'b0 || err_count !== '0) begin
         failures++;
         $display("FAIL zero: zs=%b lk=%b cnt=%0h want 1 0 0",
                  zero_sticky, locked, err_count);
      end
      g = 'h37;
      for (int i = 0; i <= LOCK; i++) begin
         step(1, g, 0);
         g = nx(g);
         if (i < LOCK) begin
            checks++;
            if (locked !== 1'b0) begin
               failures++;
               $display("FAIL gap_early%0d: locked=%b want 0", i, locked);
            end
            repeat ($urandom_range(1, 3)) step(0, $urandom_range(0, 255), 0);
         end
      end
      checks++;
      if (locked !== 1'b1 || zero_sticky !== 1'b1) begin
         failures++;
         $display("FAIL gaps: locked=%b zs=%b want 1 1", locked, zero_sticky);
      end
   endtask

   task automatic test_saturate_clear();
      int errs = 0;
      do_reset();
      lock_from(1);
      while (errs < EMAX + 20) begin
         for (int k = 0; k < 2; k++) begin
            step(1, g ^ 'h55, 0); g = nx(g); errs++;
         end
         step(1, g, 0); g = nx(g);
      end
      checks++;
      if (err_count !== EW'(EMAX) || locked !== 1'b1) begin
         failures++;
         $display("FAIL saturate: cnt=%0h lk=%b want %0h 1",
                  err_count, locked, EMAX);
      end
      step(1, 0, 0); g = nx(g);
      step(1, g, 1); g = nx(g);
      checks++;
      if (err_count !== '0 || zero_sticky !== 1'b0 || lost_sticky !== 1'b0
          || locked !== 1'b1) begin
         failures++;
         $display("FAIL clear: cnt=%0h zs=%b ls=%b lk=%b want 0 0 0 1",
                  err_count, zero_sticky, lost_sticky, locked);
      end
      step(1, g ^ 'h01, 1); g = nx(g);
      checks++;
      if (err_pulse !== 1'b1 || err_count !== '0) begin
         failures++;
         $display("FAIL clr_err: pulse=%b cnt=%0h want 1 0",
                  err_pulse, err_count);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      lock_from(1);
      step(1, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (locked !== 1'b0 || err_count !== '0 || zero_sticky !== 1'b0 ||
          lost_sticky !== 1'b0 || err_pulse !== 1'b0) begin
         failures++;
         $display("FAIL async_rst: lk=%b cnt=%0h zs=%b ls=%b p=%b want 0",
                  locked, err_count, zero_sticky, lost_sticky, err_pulse);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      int bad = 0;
      int d;
      bit v, c;
      do_reset();
      g = $urandom_range(1, 255);
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 99) == 0);
         d = g;
         if (v) begin
            case ($urandom_range(0, 29))
               0, 1, 2: d = $urandom_range(0, 255);
               3:       d = 0;
               4:       g = $urandom_range(1, 255);
               default: ;
            endcase
            if ($urandom_range(0, 29) == 4) d = g;
            g = nx(g);
         end
         step(v, d, c);
         checks++;
         if ({locked, err_pulse, lost_sticky, zero_sticky} !==
             {m_mode == 2, m_pulse, m_lost, m_zero} ||
             err_count !== EW'(m_cnt)) begin
            failures++;
            if (bad++ < 10)
               $display("FAIL random@%0d: lk/p/ls/zs=%b cnt=%0h want %b %0h",
                        i, {locked, err_pulse, lost_sticky, zero_sticky},
                        err_count, {m_mode == 2, m_pulse, m_lost, m_zero},
                        m_cnt);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lock();
      test_single_corrupt();
      test_loss();
      test_zero_gaps();
      test_saturate_clear();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
